// File: rtl/display_scan_if.sv
// Bundle of the display scanner's data-side signals.
//   master : drives load/digits/blank_mask/enable, observes code/an/frame_start/pending
//   slave  : the scanner itself, the mirror image of master
// NUM_DIGITS must match the scanner instance it is attached to.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic                      enable;
    logic [3:0]                code;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_start;
    logic                      pending;

    modport master (
        output load, digits, blank_mask, enable,
        input  code, an, frame_start, pending
    );

    modport slave (
        input  load, digits, blank_mask, enable,
        output code, an, frame_start, pending
    );
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// One 4-bit code per digit is presented per slot on bus.code, with the
// matching active-low anode on bus.an. Updates are double-buffered and are
// applied only at a frame boundary; each slot begins with DEAD dark cycles.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    display_scan_if.slave: load/digits/blank_mask/enable in,
//          code/an/frame_start/pending out (all outputs registered)
module display_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int DEAD       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    display_scan_if.slave  bus
);

    localparam int DIV_W  = (DIV > 1)        ? $clog2(DIV)        : 1;
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]          divCnt_q,       divCnt_d;
    logic [SLOT_W-1:0]         slot_q,         slot_d;
    logic [4*NUM_DIGITS-1:0]   activeDigits_q, activeDigits_d;
    logic [NUM_DIGITS-1:0]     activeBlank_q,  activeBlank_d;
    logic [4*NUM_DIGITS-1:0]   pendDigits_q,   pendDigits_d;
    logic [NUM_DIGITS-1:0]     pendBlank_q,    pendBlank_d;
    logic                      pending_q,      pending_d;
    logic [3:0]                code_q,         code_d;
    logic [NUM_DIGITS-1:0]     an_q,           an_d;
    logic                      frameStart_q,   frameStart_d;

    logic slotEnd;
    logic boundary;

    assign slotEnd  = (divCnt_q == DIV_W'(DIV - 1));
    assign boundary = slotEnd && (slot_q == SLOT_W'(NUM_DIGITS - 1));

    // Next-state logic. At a boundary the apply reads the old pending buffer
    // while a coincident load writes the new one, so that load survives
    // (pending stays set) and is shown one frame later.
    always_comb begin
        divCnt_d       = divCnt_q + 1'b1;
        slot_d         = slot_q;
        activeDigits_d = activeDigits_q;
        activeBlank_d  = activeBlank_q;
        pendDigits_d   = pendDigits_q;
        pendBlank_d    = pendBlank_q;
        pending_d      = pending_q;

        if (slotEnd) begin
            divCnt_d = '0;
            slot_d   = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
        end

        if (boundary && pending_q) begin
            activeDigits_d = pendDigits_q;
            activeBlank_d  = pendBlank_q;
            pending_d      = 1'b0;
        end

        if (bus.load) begin
            pendDigits_d = bus.digits;
            pendBlank_d  = bus.blank_mask;
            pending_d    = 1'b1;
        end
    end

    // Output stage: reflects the current (slot, divCnt) one cycle later.
    // The slot changes at divCnt 0, which is always inside the dead window,
    // so the code never changes while an anode is low.
    always_comb begin
        code_d       = activeDigits_q[4*slot_q +: 4];
        an_d         = '1;
        frameStart_d = boundary;
        if (bus.enable && !activeBlank_q[slot_q] && (divCnt_q >= DIV_W'(DEAD))) begin
            an_d[slot_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt_q       <= '0;
            slot_q         <= '0;
            activeDigits_q <= '0;
            activeBlank_q  <= '1;
            pendDigits_q   <= '0;
            pendBlank_q    <= '0;
            pending_q      <= 1'b0;
            code_q         <= '0;
            an_q           <= '1;
            frameStart_q   <= 1'b0;
        end else begin
            divCnt_q       <= divCnt_d;
            slot_q         <= slot_d;
            activeDigits_q <= activeDigits_d;
            activeBlank_q  <= activeBlank_d;
            pendDigits_q   <= pendDigits_d;
            pendBlank_q    <= pendBlank_d;
            pending_q      <= pending_d;
            code_q         <= code_d;
            an_q           <= an_d;
            frameStart_q   <= frameStart_d;
        end
    end

    assign bus.code        = code_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frameStart_q;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan (4 digits, 8 cycles/slot, 2 dead cycles).
// A reference model predicts every cycle's outputs from the time index since
// reset and pushes them into a queue; a monitor pops and compares each cycle.
module tb_display_scan;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N * DIV;

    typedef struct packed {
        logic [3:0]   code;
        logic [N-1:0] an;
        logic         fs;
        logic         pend;
    } exp_t;

    logic clk;
    logic rst_n;

    display_scan_if #(.NUM_DIGITS(N)) bus ();

    display_scan #(.NUM_DIGITS(N), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t expQ[$];

    // Reference model state: time index since reset release plus the
    // displayed and buffered digit sets.
    int         mT;
    logic [3:0] mActive[N];
    logic       mBlank[N];
    logic [3:0] mPendD[N];
    logic       mPendB[N];
    logic       mPending;
    int         mSlot;
    int         mPos;
    bit         mBnd;
    exp_t       mExp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: plain arithmetic on the cycle index.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mT       = 0;
                mPending = 1'b0;
                for (int i = 0; i < N; i++) begin
                    mActive[i] = 4'h0;
                    mBlank[i]  = 1'b1;
                    mPendD[i]  = 4'h0;
                    mPendB[i]  = 1'b0;
                end
            end else begin
                mSlot     = (mT / DIV) % N;
                mPos      = mT % DIV;
                mBnd      = ((mT + 1) % FRAME) == 0;
                mExp.code = mActive[mSlot];
                mExp.an   = '1;
                if (bus.enable && !mBlank[mSlot] && mPos >= DEAD)
                    mExp.an[mSlot] = 1'b0;
                mExp.fs = mBnd;
                if (mBnd && mPending) begin
                    for (int i = 0; i < N; i++) begin
                        mActive[i] = mPendD[i];
                        mBlank[i]  = mPendB[i];
                    end
                    mPending = 1'b0;
                end
                if (bus.load) begin
                    for (int i = 0; i < N; i++) begin
                        mPendD[i] = bus.digits[4*i +: 4];
                        mPendB[i] = bus.blank_mask[i];
                    end
                    mPending = 1'b1;
                end
                mExp.pend = mPending;
                expQ.push_back(mExp);
                mT++;
            end
        end
    end

    // Monitor: every clocked cycle out of reset yields one expected record.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL scoreboard t=%0t: queue empty, actual=0 entries required>=1", $time);
                end else begin
                    e = expQ.pop_front();
                    if (bus.code !== e.code || bus.an !== e.an ||
                        bus.frame_start !== e.fs || bus.pending !== e.pend) begin
                        miscompares++;
                        $display("[TB] FAIL cycle t=%0t: actual code=%h an=%b fs=%b pend=%b, required code=%h an=%b fs=%b pend=%b",
                                 $time, bus.code, bus.an, bus.frame_start, bus.pending,
                                 e.code, e.an, e.fs, e.pend);
                    end
                end
            end
        end
    end

    // Direct check of the asynchronous reset values.
    task automatic checkOutput(input string name);
        vectors++;
        if (bus.code !== 4'h0 || bus.an !== 4'hF || bus.frame_start !== 1'b0 || bus.pending !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s: actual code=%h an=%b fs=%b pend=%b, required code=0 an=1111 fs=0 pend=0",
                     name, bus.code, bus.an, bus.frame_start, bus.pending);
        end
    endtask

    // Called at a negedge: one-cycle load strobe.
    task automatic applyStimulus(input logic [4*N-1:0] d, input logic [N-1:0] b);
        bus.digits     = d;
        bus.blank_mask = b;
        bus.load       = 1'b1;
        @(negedge clk);
        bus.load       = 1'b0;
    endtask

    // Advance to the negedge whose following rising edge processes frame phase p.
    task automatic waitPhase(input int p);
        for (int k = 0; k < 2*FRAME; k++) begin
            @(negedge clk);
            if ((mT % FRAME) == p) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL waitPhase: phase %0d not reached, actual=timeout required=reached", p);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.load       = 1'b0;
        bus.digits     = '0;
        bus.blank_mask = '0;
        bus.enable     = 1'b1;
        #12;
        checkOutput("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic load 4321");
        applyStimulus(16'h4321, 4'b0000);
        waitCycles(3*FRAME);

        $display("[TB] blank digit 2");
        waitPhase(5);
        applyStimulus(16'h4321, 4'b0100);
        waitCycles(2*FRAME);

        $display("[TB] load coinciding with boundary");
        waitPhase(10);
        applyStimulus(16'h5678, 4'b0000);
        waitPhase(FRAME-1);
        applyStimulus(16'hABCD, 4'b0000);
        waitCycles(3*FRAME);

        $display("[TB] two loads in one frame");
        waitPhase(3);
        applyStimulus(16'h1111, 4'b0000);
        waitPhase(15);
        applyStimulus(16'h2222, 4'b0000);
        waitCycles(2*FRAME);

        $display("[TB] enable toggling");
        waitPhase(DIV + 3);
        bus.enable = 1'b0;
        waitPhase(3*DIV + 5);
        bus.enable = 1'b1;
        waitCycles(FRAME);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 9) == 0) begin
                bus.digits     = 16'($urandom);
                bus.blank_mask = 4'($urandom);
                bus.load       = 1'b1;
            end
        end
        @(negedge clk);
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        waitCycles(2*FRAME);

        $display("[TB] asynchronous reset mid-frame");
        waitPhase(13);
        applyStimulus(16'h9876, 4'b0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async");
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(FRAME + 4);
        applyStimulus(16'h0F5A, 4'b0010);
        waitCycles(2*FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
